// File: rtl/rtc_alarm_ctrl.sv
// HH:MM:SS real-time clock with alarm, button-driven set/alarm mode FSM,
// on-chip debouncing and a multiplexed 6-digit seven-segment display.
module rtc_alarm_ctrl #(
  parameter int CLK_HZ   = 100,
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btnl_i,
  input  logic       btnr_i,
  input  logic       btnu_i,
  input  logic       btnd_i,
  input  logic       alarm_en_i,
  output logic [7:0] led7_seg_o,
  output logic [7:0] led7_an_o,
  output logic       alarm_o,
  output logic [2:0] mode_o
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int HALF  = (CLK_HZ / 2 > 1) ? CLK_HZ / 2 : 1;
  localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    AL_H  = 3'd4,
    AL_M  = 3'd5
  } mode_t;

  function automatic mode_t mode_fwd(input mode_t m);
    case (m)
      RUN:     return SET_H;
      SET_H:   return SET_M;
      SET_M:   return SET_S;
      SET_S:   return AL_H;
      AL_H:    return AL_M;
      default: return RUN;
    endcase
  endfunction

  function automatic mode_t mode_bwd(input mode_t m);
    case (m)
      RUN:     return AL_M;
      SET_H:   return RUN;
      SET_M:   return SET_H;
      SET_S:   return SET_M;
      AL_H:    return SET_S;
      AL_M:    return AL_H;
      default: return RUN;
    endcase
  endfunction

  // +1/-1 modulo m with no carry out.
  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] m,
                                          input logic up);
    if (up) return (v == m - 6'd1) ? 6'd0 : v + 6'd1;
    else    return (v == 6'd0) ? m - 6'd1 : v - 6'd1;
  endfunction

  function automatic logic [3:0] tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] units(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Bit order everywhere: [3]=right, [2]=left, [1]=up, [0]=down.
  logic [3:0]      raw, sync1, sync2, level, press;
  logic [DB_W-1:0] db_cnt [4];

  assign raw = {btnr_i, btnl_i, btnu_i, btnd_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Pulse on the cycle the rising level is accepted, so it lands with the level update.
  always_comb begin
    for (int i = 0; i < 4; i++)
      press[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_W'(DEBOUNCE - 1));
  end

  mode_t state, state_n;
  logic  do_up, do_dn;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= RUN;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    do_up   = 1'b0;
    do_dn   = 1'b0;
    case (state)
      RUN, SET_H, SET_M, SET_S, AL_H, AL_M: begin
        if (press[3])      state_n = mode_fwd(state);
        else if (press[2]) state_n = mode_bwd(state);
        else if (press[1]) do_up   = 1'b1;
        else if (press[0]) do_dn   = 1'b1;
      end
      default: state_n = RUN;
    endcase
  end

  assign mode_o = state;

  logic [PRE_W-1:0] pre;
  logic             tick;
  logic [4:0]       hour, al_hour, hr_n, alh_n;
  logic [5:0]       minute, second, al_min, min_n, sec_n, alm_n;

  assign tick = (state == RUN) && (pre == PRE_W'(CLK_HZ - 1));

  always_comb begin
    sec_n = second;
    min_n = minute;
    hr_n  = hour;
    alh_n = al_hour;
    alm_n = al_min;
    if (tick) begin
      if (second == 6'd59) begin
        sec_n = '0;
        if (minute == 6'd59) begin
          min_n = '0;
          hr_n  = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
        end else begin
          min_n = minute + 6'd1;
        end
      end else begin
        sec_n = second + 6'd1;
      end
    end
    if (do_up || do_dn) begin
      case (state)
        SET_H:   hr_n  = 5'(step_mod({1'b0, hour}, 6'd24, do_up));
        SET_M:   min_n = step_mod(minute, 6'd60, do_up);
        SET_S:   sec_n = step_mod(second, 6'd60, do_up);
        AL_H:    alh_n = 5'(step_mod({1'b0, al_hour}, 6'd24, do_up));
        AL_M:    alm_n = step_mod(al_min, 6'd60, do_up);
        default: ;
      endcase
    end
  end

  // Prescaler idles at zero outside RUN, so re-entering RUN starts a full second.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre     <= '0;
      hour    <= '0;
      minute  <= '0;
      second  <= '0;
      al_hour <= '0;
      al_min  <= '0;
      alarm_o <= 1'b0;
    end else begin
      pre     <= (state != RUN || tick) ? '0 : pre + PRE_W'(1);
      hour    <= hr_n;
      minute  <= min_n;
      second  <= sec_n;
      al_hour <= alh_n;
      al_min  <= alm_n;
      if ((|press) || !alarm_en_i || state != RUN)
        alarm_o <= 1'b0;
      else if (tick && sec_n == 6'd0)
        alarm_o <= (hr_n == al_hour) && (min_n == al_min);
    end
  end

  logic [SCN_W-1:0] sdiv;
  logic [2:0]       idx;
  logic [BLK_W-1:0] bcnt;
  logic             blink;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sdiv  <= '0;
      idx   <= '0;
      bcnt  <= '0;
      blink <= 1'b0;
    end else begin
      if (sdiv == SCN_W'(SCAN_DIV - 1)) begin
        sdiv <= '0;
        idx  <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        sdiv <= sdiv + SCN_W'(1);
      end
      if (bcnt == BLK_W'(HALF - 1)) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + BLK_W'(1);
      end
    end
  end

  logic       show_al, sel, blank;
  logic [5:0] d_hr, d_min;
  logic [3:0] dval;
  logic [7:0] seg_n;

  always_comb begin
    show_al = (state == AL_H) || (state == AL_M);
    d_hr    = show_al ? {1'b0, al_hour} : {1'b0, hour};
    d_min   = show_al ? al_min : minute;
    case (idx)
      3'd0:    dval = units(second);
      3'd1:    dval = tens(second);
      3'd2:    dval = units(d_min);
      3'd3:    dval = tens(d_min);
      3'd4:    dval = units(d_hr);
      default: dval = tens(d_hr);
    endcase
    case (state)
      SET_H, AL_H: sel = (idx == 3'd4) || (idx == 3'd5);
      SET_M, AL_M: sel = (idx == 3'd2) || (idx == 3'd3);
      SET_S:       sel = (idx == 3'd0) || (idx == 3'd1);
      default:     sel = 1'b0;
    endcase
    blank = (show_al && idx < 3'd2) || (blink && sel);
    seg_n = blank ? 8'hFF : {1'b1, seg_enc(dval)};
    if (idx == 3'd2 || idx == 3'd4) seg_n[7] = 1'b0;
  end

  // Display register stage: anode and segments leave together, one cycle behind idx.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led7_an_o  <= 8'hFE;
      led7_seg_o <= 8'hC0;
    end else begin
      led7_an_o  <= ~(8'd1 << idx);
      led7_seg_o <= seg_n;
    end
  end

endmodule

// File: tb/tb_rtc_alarm_ctrl.sv
// Scoreboard bench for rtc_alarm_ctrl: a behavioural clock/alarm model queues the
// expected {mode, alarm, anode, segments} each cycle; a monitor pops and compares.
module tb_rtc_alarm_ctrl;
  localparam int CLK_HZ   = 100;
  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 4;
  localparam int HALF     = CLK_HZ / 2;
  localparam int HOLD     = DEBOUNCE + 1;

  logic       clk = 1'b0, rst = 1'b0;
  logic       btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0, alarm_en = 1'b0;
  logic [7:0] seg, an;
  logic       alarm;
  logic [2:0] mode;

  int tests = 0, fails = 0;
  int e_cnt = 0, m_mode = 0, m_tod = 0, m_ah = 0, m_am = 0, m_run = 0;
  bit m_alarm = 1'b0;
  bit [3:0]    press_at [int];
  logic [19:0] exp_q [$];

  rtc_alarm_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk_i(clk), .rst_i(rst), .btnl_i(btnl), .btnr_i(btnr), .btnu_i(btnu), .btnd_i(btnd),
    .alarm_en_i(alarm_en), .led7_seg_o(seg), .led7_an_o(an), .alarm_o(alarm), .mode_o(mode)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // One clock edge of the reference clock: display from pre-edge state, then update.
  task automatic model_edge();
    int idx, bl, h, mi, s, dh, dm, val, nh, nm, ns, nmode, dlt, t;
    bit [3:0] p;
    bit tick, blank, sel;
    logic [7:0] sg, a;
    idx = (e_cnt / SCAN_DIV) % 6;
    bl  = (e_cnt / HALF) % 2;
    h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
    dh = (m_mode >= 4) ? m_ah : h;
    dm = (m_mode >= 4) ? m_am : mi;
    case (idx)
      0: val = s % 10;  1: val = s / 10;
      2: val = dm % 10; 3: val = dm / 10;
      4: val = dh % 10; default: val = dh / 10;
    endcase
    sel = ((m_mode == 1 || m_mode == 4) && idx >= 4) ||
          ((m_mode == 2 || m_mode == 5) && (idx == 2 || idx == 3)) ||
          (m_mode == 3 && idx < 2);
    blank = (m_mode >= 4 && idx < 2) || (bl == 1 && sel);
    sg = blank ? 8'hFF : seg_of(val);
    if (idx == 2 || idx == 4) sg[7] = 1'b0;
    a = ~(8'd1 << idx);

    p = press_at.exists(e_cnt + 1) ? press_at[e_cnt + 1] : 4'd0;
    tick = (m_mode == 0) && (m_run % CLK_HZ == CLK_HZ - 1);
    nh = h; nm = mi; ns = s; nmode = m_mode;
    if (tick) begin
      t = (m_tod + 1) % 86400;
      nh = t / 3600; nm = (t / 60) % 60; ns = t % 60;
    end
    if (p[3]) nmode = (m_mode + 1) % 6;
    else if (p[2]) nmode = (m_mode + 5) % 6;
    else if (p[1] || p[0]) begin
      dlt = p[1] ? 1 : -1;
      case (m_mode)
        1: nh   = (h + dlt + 24) % 24;
        2: nm   = (mi + dlt + 60) % 60;
        3: ns   = (s + dlt + 60) % 60;
        4: m_ah = (m_ah + dlt + 24) % 24;
        5: m_am = (m_am + dlt + 60) % 60;
        default: ;
      endcase
    end
    if (p != 0 || alarm_en !== 1'b1 || m_mode != 0) m_alarm = 1'b0;
    else if (tick && ns == 0) m_alarm = (nh == m_ah) && (nm == m_am);
    m_run = (m_mode == 0) ? m_run + 1 : 0;
    m_tod = nh * 3600 + nm * 60 + ns;
    m_mode = nmode;
    exp_q.push_back({3'(nmode), m_alarm, a, sg});
    e_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic set_btns(input logic [3:0] mask);
    {btnr, btnl, btnu, btnd} = mask;
  endtask

  // Clean press held for 'hold' cycles; accepted presses act DEBOUNCE+2 edges later.
  task automatic press(input logic [3:0] mask, input int hold);
    int key;
    key = e_cnt + DEBOUNCE + 2;
    set_btns(mask);
    if (hold >= DEBOUNCE)
      press_at[key] = (press_at.exists(key) ? press_at[key] : 4'd0) | mask;
    steps(hold);
    set_btns(4'd0);
    steps(DEBOUNCE + 6);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_btns(4'd0);
    exp_q.delete();
    #1;
    check("rst_an", 20'(an), 20'hFE);
    check("rst_seg", 20'(seg), 20'hC0);
    check("rst_mode", 20'(mode), 20'd0);
    check("rst_alarm", 20'(alarm), 20'd0);
    #1;
    rst = 1'b0;
    e_cnt = 0; m_mode = 0; m_tod = 0; m_ah = 0; m_am = 0; m_run = 0; m_alarm = 1'b0;
    press_at.delete();
  endtask

  task automatic setup_alarm_0001();
    press(4'b0100, HOLD);   // RUN -> AL_M
    press(4'b0010, HOLD);   // alarm minute 01
    press(4'b1000, HOLD);   // back to RUN
  endtask

  always @(negedge clk) begin : monitor
    logic [19:0] want;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      check("sb", {mode, alarm, an, seg}, want);
    end
  end

  initial begin
    int k;
    logic [3:0] mask;
    #1 do_reset();
    steps(230);

    // Press latency and bounce rejection on btnr.
    k = e_cnt;
    btnr = 1'b1;
    press_at[k + DEBOUNCE + 2] = 4'b1000;
    steps(DEBOUNCE + 1);
    check("lat_before", 20'(mode), 20'd0);
    step();
    check("lat_after", 20'(mode), 20'd1);
    btnr = 1'b0;
    steps(DEBOUNCE + 6);
    press(4'b1000, 3);
    check("bounce", 20'(mode), 20'd1);

    // Hour/minute/second editing, then roll 23:59:59 over.
    press(4'b0001, HOLD);
    repeat (2) press(4'b0010, HOLD);
    repeat (2) press(4'b0001, HOLD);
    press(4'b1000, HOLD);
    press(4'b0001, HOLD);
    press(4'b0010, HOLD);
    press(4'b0001, HOLD);
    press(4'b1000, HOLD);
    k = (m_tod % 60 + 1) % 60;
    repeat (k) press(4'b0001, HOLD);
    repeat (3) press(4'b1000, HOLD);
    steps(250);

    // Coincident right+up in SET_H: mode advances, hour untouched.
    press(4'b1000, HOLD);
    press(4'b1010, HOLD);
    check("coinc_mode", 20'(mode), 20'd2);
    repeat (4) press(4'b1000, HOLD);

    // Alarm cleared by a press.
    do_reset();
    setup_alarm_0001();
    alarm_en = 1'b1;
    for (int i = 0; i < 7000 && !m_alarm; i++) step();
    check("alarm_rise", 20'(alarm), 20'd1);
    steps(30);
    press(4'b0010, HOLD);
    check("alarm_press_clr", 20'(alarm), 20'd0);

    // Alarm expiring on its own at the next minute.
    do_reset();
    setup_alarm_0001();
    alarm_en = 1'b1;
    for (int i = 0; i < 7000 && !m_alarm; i++) step();
    check("alarm_rise2", 20'(alarm), 20'd1);
    for (int i = 0; i < 7000 && m_tod < 120; i++) step();
    steps(2);
    check("alarm_auto_clr", 20'(alarm), 20'd0);

    // Reset in the middle of editing 12:34.
    do_reset();
    press(4'b1000, HOLD);
    repeat (12) press(4'b0010, HOLD);
    press(4'b1000, HOLD);
    repeat (34) press(4'b0010, HOLD);
    do_reset();
    steps(150);

    // Randomised presses, bounces and enable changes around an alarm minute.
    do_reset();
    setup_alarm_0001();
    alarm_en = 1'b1;
    steps(5900);
    for (int i = 0; i < 60; i++) begin
      mask = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) mask = mask | 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) alarm_en = ~alarm_en;
      press(mask, $urandom_range(1, DEBOUNCE + 3));
      steps($urandom_range(0, 120));
    end
    steps(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
